// File: rtl/mips_alu.sv
// Execute-stage ALU with the architectural HI/LO registers.
// Ports: iCLK, iRST, iControlSignal, iA, iB, iShamt -> oALUresult, oZero, oOverflow
module mips_alu (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [4:0]  iControlSignal,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic [4:0]  iShamt,
  output logic [31:0] oALUresult,
  output logic        oZero,
  output logic        oOverflow
);

  localparam logic [4:0] OpAnd   = 5'd0;
  localparam logic [4:0] OpOr    = 5'd1;
  localparam logic [4:0] OpAdd   = 5'd2;
  localparam logic [4:0] OpMfhi  = 5'd3;
  localparam logic [4:0] OpSll   = 5'd4;
  localparam logic [4:0] OpMflo  = 5'd5;
  localparam logic [4:0] OpSub   = 5'd6;
  localparam logic [4:0] OpSlt   = 5'd7;
  localparam logic [4:0] OpSrl   = 5'd8;
  localparam logic [4:0] OpSra   = 5'd9;
  localparam logic [4:0] OpXor   = 5'd10;
  localparam logic [4:0] OpSltu  = 5'd11;
  localparam logic [4:0] OpNor   = 5'd12;
  localparam logic [4:0] OpMult  = 5'd13;
  localparam logic [4:0] OpMultu = 5'd14;
  localparam logic [4:0] OpDiv   = 5'd15;
  localparam logic [4:0] OpDivu  = 5'd16;
  localparam logic [4:0] OpMthi  = 5'd17;
  localparam logic [4:0] OpMtlo  = 5'd18;
  localparam logic [4:0] OpSllv  = 5'd19;
  localparam logic [4:0] OpSrlv  = 5'd20;
  localparam logic [4:0] OpSrav  = 5'd21;
  localparam logic [4:0] OpAddu  = 5'd22;
  localparam logic [4:0] OpSubu  = 5'd23;

  logic [31:0] hi;
  logic [31:0] lo;

  logic [31:0] sum;
  logic [31:0] diff;
  logic        addOvf;
  logic        subOvf;

  assign sum  = iA + iB;
  assign diff = iA - iB;

  // Overflow from sign bits: same-sign add flips, or
  // mixed-sign subtract lands opposite to A.
  assign addOvf = (iA[31] == iB[31]) &&
                  (sum[31] != iA[31]);
  assign subOvf = (iA[31] != iB[31]) &&
                  (diff[31] != iA[31]);

  logic [4:0]  varAmt;
  logic [31:0] sraFix;
  logic [31:0] sraVar;

  assign varAmt = iA[4:0];
  assign sraFix = $signed(iB) >>> iShamt;
  assign sraVar = $signed(iB) >>> varAmt;

  logic [63:0] prodS;
  logic [63:0] prodU;

  assign prodS = {{32{iA[31]}}, iA} *
                 {{32{iB[31]}}, iB};
  assign prodU = {32'b0, iA} * {32'b0, iB};

  // Signed divide runs on magnitudes so the
  // 0x80000000 / -1 case wraps cleanly instead of
  // relying on signed-division corner behaviour.
  logic        divByZero;
  logic [31:0] aMag;
  logic [31:0] bMag;
  logic [31:0] bMagSafe;
  logic [31:0] bSafe;
  logic [31:0] magQ;
  logic [31:0] magR;
  logic [31:0] sQuot;
  logic [31:0] sRem;
  logic [31:0] uQuot;
  logic [31:0] uRem;

  assign divByZero = (iB == 32'd0);
  assign aMag  = iA[31] ? (~iA + 32'd1) : iA;
  assign bMag  = iB[31] ? (~iB + 32'd1) : iB;

  // Divisor forced to 1 on zero; the result is
  // discarded then, this just keeps the divider defined.
  assign bMagSafe = divByZero ? 32'd1 : bMag;
  assign bSafe    = divByZero ? 32'd1 : iB;

  assign magQ = aMag / bMagSafe;
  assign magR = aMag % bMagSafe;

  assign sQuot = (iA[31] ^ iB[31]) ?
                 (~magQ + 32'd1) : magQ;
  assign sRem  = iA[31] ? (~magR + 32'd1) : magR;

  assign uQuot = iA / bSafe;
  assign uRem  = iA % bSafe;

  logic [31:0] result;
  logic        ovf;

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    unique case (iControlSignal)
      OpAnd:  result = iA & iB;
      OpOr:   result = iA | iB;
      OpAdd: begin
        result = sum;
        ovf    = addOvf;
      end
      OpMfhi: result = hi;
      OpSll:  result = iB << iShamt;
      OpMflo: result = lo;
      OpSub: begin
        result = diff;
        ovf    = subOvf;
      end
      OpSlt:
        result = {31'b0,
                  $signed(iA) < $signed(iB)};
      OpSrl:  result = iB >> iShamt;
      OpSra:  result = sraFix;
      OpXor:  result = iA ^ iB;
      OpSltu: result = {31'b0, iA < iB};
      OpNor:  result = ~(iA | iB);
      OpSllv: result = iB << varAmt;
      OpSrlv: result = iB >> varAmt;
      OpSrav: result = sraVar;
      OpAddu: result = sum;
      OpSubu: result = diff;
      default: begin
        result = '0;
        ovf    = 1'b0;
      end
    endcase
  end

  assign oALUresult = result;
  assign oOverflow  = ovf;
  assign oZero      = (result == 32'd0);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      hi <= '0;
      lo <= '0;
    end else begin
      unique case (iControlSignal)
        OpMult: begin
          hi <= prodS[63:32];
          lo <= prodS[31:0];
        end
        OpMultu: begin
          hi <= prodU[63:32];
          lo <= prodU[31:0];
        end
        OpDiv: begin
          if (!divByZero) begin
            hi <= sRem;
            lo <= sQuot;
          end
        end
        OpDivu: begin
          if (!divByZero) begin
            hi <= uRem;
            lo <= uQuot;
          end
        end
        OpMthi: hi <= iA;
        OpMtlo: lo <= iA;
        default: begin
          hi <= hi;
          lo <= lo;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Bench for mips_alu: literal checks plus a
// randomized run against an arithmetic model.
module tb_mips_alu;

  localparam logic [4:0] AND_  = 5'd0;
  localparam logic [4:0] ADD   = 5'd2;
  localparam logic [4:0] MFHI  = 5'd3;
  localparam logic [4:0] MFLO  = 5'd5;
  localparam logic [4:0] SUB   = 5'd6;
  localparam logic [4:0] SLT   = 5'd7;
  localparam logic [4:0] SRA   = 5'd9;
  localparam logic [4:0] SLTU  = 5'd11;
  localparam logic [4:0] MULT  = 5'd13;
  localparam logic [4:0] MULTU = 5'd14;
  localparam logic [4:0] DIV   = 5'd15;
  localparam logic [4:0] DIVU  = 5'd16;
  localparam logic [4:0] MTHI  = 5'd17;
  localparam logic [4:0] MTLO  = 5'd18;
  localparam logic [4:0] SRLV  = 5'd20;
  localparam logic [4:0] ADDU  = 5'd22;

  logic        iCLK;
  logic        iRST;
  logic [4:0]  iControlSignal;
  logic [31:0] iA;
  logic [31:0] iB;
  logic [4:0]  iShamt;
  logic [31:0] oALUresult;
  logic        oZero;
  logic        oOverflow;

  mips_alu dut (
    .iCLK          (iCLK),
    .iRST          (iRST),
    .iControlSignal(iControlSignal),
    .iA            (iA),
    .iB            (iB),
    .iShamt        (iShamt),
    .oALUresult    (oALUresult),
    .oZero         (oZero),
    .oOverflow     (oOverflow)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int nErr = 0;
  int nChk = 0;
  bit modelOn = 1'b0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, want %h",
               nm, got, exp);
    end
  endtask

  // Result/overflow from plain 64-bit arithmetic.
  function automatic void model(
    input  logic [4:0]  c,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  sh,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] r,
    output logic        v);
    longint sa, sb, s, maxI, minI;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    maxI = 64'sd2147483647;
    minI = -maxI - 1;
    r = '0;
    v = 1'b0;
    case (c)
      0:  r = a & b;
      1:  r = a | b;
      2: begin
        s = sa + sb;
        r = s[31:0];
        v = (s > maxI) || (s < minI);
      end
      3:  r = hi;
      4:  r = b << sh;
      5:  r = lo;
      6: begin
        s = sa - sb;
        r = s[31:0];
        v = (s > maxI) || (s < minI);
      end
      7:  r = (sa < sb) ? 32'd1 : 32'd0;
      8:  r = b >> sh;
      9: begin
        s = sb >>> sh;
        r = s[31:0];
      end
      10: r = a ^ b;
      11: r = (a < b) ? 32'd1 : 32'd0;
      12: r = ~(a | b);
      19: r = b << a[4:0];
      20: r = b >> a[4:0];
      21: begin
        s = sb >>> a[4:0];
        r = s[31:0];
      end
      22: r = a + b;
      23: r = a - b;
      default: r = '0;
    endcase
  endfunction

  function automatic void modelWrite(
    input  logic [4:0]  c,
    input  logic [31:0] a,
    input  logic [31:0] b,
    inout  logic [31:0] hi,
    inout  logic [31:0] lo);
    longint sa, sb, p, q, rm;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c)
      13: begin
        p  = sa * sb;
        hi = p[63:32];
        lo = p[31:0];
      end
      14: begin
        pu = {32'b0, a} * {32'b0, b};
        hi = pu[63:32];
        lo = pu[31:0];
      end
      15: if (b != 0) begin
        q  = sa / sb;
        rm = sa % sb;
        hi = rm[31:0];
        lo = q[31:0];
      end
      16: if (b != 0) begin
        hi = a % b;
        lo = a / b;
      end
      17: hi = a;
      18: lo = a;
      default: ;
    endcase
  endfunction

  always @(posedge iCLK)
    if (!iRST)
      modelWrite(iControlSignal, iA, iB, mHi, mLo);

  always @(posedge iRST) begin
    mHi = '0;
    mLo = '0;
  end

  // Single compare point, mid-cycle.
  always @(negedge iCLK) begin
    logic [31:0] er;
    logic        ev;
    if (modelOn) begin
      model(iControlSignal, iA, iB, iShamt,
            mHi, mLo, er, ev);
      chk($sformatf("model res op%0d",
                    iControlSignal),
          oALUresult, er);
      chk("model ovf", {31'b0, oOverflow},
          {31'b0, ev});
      chk("model zero", {31'b0, oZero},
          {31'b0, er == 0});
    end
  end

  task automatic put(input logic [4:0] c,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [4:0] sh);
    @(posedge iCLK);
    #1;
    iControlSignal = c;
    iA = a;
    iB = b;
    iShamt = sh;
  endtask

  task automatic look(input string nm,
                      input logic [31:0] exp);
    #1;
    chk(nm, oALUresult, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    iRST = 1'b1;
    iControlSignal = AND_;
    iA = '0;
    iB = '0;
    iShamt = '0;
    repeat (2) @(posedge iCLK);
    #1 iRST = 1'b0;
    modelOn = 1'b1;

    put(MFHI, 0, 0, 0);
    look("reset hi", 32'h0);
    put(MFLO, 0, 0, 0);
    look("reset lo", 32'h0);

    put(ADD, 32'h7FFF_FFFF, 32'h1, 0);
    look("add res", 32'h8000_0000);
    chk("add ovf", {31'b0, oOverflow}, 32'd1);
    chk("add zero", {31'b0, oZero}, 32'd0);
    put(ADDU, 32'h7FFF_FFFF, 32'h1, 0);
    #1 chk("addu ovf", {31'b0, oOverflow}, 32'd0);
    put(SUB, 32'd5, 32'd5, 0);
    look("sub res", 32'h0);
    chk("sub zero", {31'b0, oZero}, 32'd1);

    put(SLT, 32'hFFFF_FFFF, 32'h1, 0);
    look("slt", 32'h1);
    put(SLTU, 32'hFFFF_FFFF, 32'h1, 0);
    look("sltu", 32'h0);
    put(SRA, 0, 32'h8000_0000, 5'd4);
    look("sra", 32'hF800_0000);
    put(SRLV, 32'd4, 32'h8000_0000, 0);
    look("srlv", 32'h0800_0000);

    put(MULT, 32'hFFFF_FFFE, 32'd3, 0);
    put(MFHI, 0, 0, 0);
    look("mult hi", 32'hFFFF_FFFF);
    put(MFLO, 0, 0, 0);
    look("mult lo", 32'hFFFF_FFFA);
    put(MULTU, 32'hFFFF_FFFE, 32'd3, 0);
    put(MFHI, 0, 0, 0);
    look("multu hi", 32'h0000_0002);
    put(MFLO, 0, 0, 0);
    look("multu lo", 32'hFFFF_FFFA);

    put(DIV, -32'sd7, 32'd2, 0);
    put(MFLO, 0, 0, 0);
    look("div lo", 32'hFFFF_FFFD);
    put(DIVU, 32'd99, 32'd0, 0);
    put(MFHI, 0, 0, 0);
    look("div0 hi", 32'hFFFF_FFFF);
    put(MFLO, 0, 0, 0);
    look("div0 lo", 32'hFFFF_FFFD);
    put(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    put(MFLO, 0, 0, 0);
    look("divmin lo", 32'h8000_0000);
    put(MFHI, 0, 0, 0);
    look("divmin hi", 32'h0);

    put(MTHI, 32'h1234_5678, 0, 0);
    put(MFHI, 0, 0, 0);
    look("mthi", 32'h1234_5678);
    iRST = 1'b1;
    look("async rst", 32'h0);
    #1 iRST = 1'b0;

    put(MTHI, 32'hCAFE_F00D, 0, 0);
    put(MTLO, 32'h0BAD_BEEF, 0, 0);
    for (int c = 24; c < 32; c++) begin
      put(5'(c), $urandom, $urandom,
          5'($urandom_range(31)));
      look($sformatf("op%0d res", c), 32'h0);
      chk("hole zero", {31'b0, oZero}, 32'd1);
      chk("hole ovf", {31'b0, oOverflow}, 32'd0);
    end
    put(MFHI, 0, 0, 0);
    look("hole hi", 32'hCAFE_F00D);
    put(MFLO, 0, 0, 0);
    look("hole lo", 32'h0BAD_BEEF);

    for (int i = 0; i < 4000; i++) begin
      put(5'($urandom_range(31)), pick(), pick(),
          5'($urandom_range(31)));
      if ($urandom_range(63) == 0) begin
        #1 iRST = 1'b1;
        #1 iRST = 1'b0;
      end
    end

    put(AND_, 0, 0, 0);
    @(negedge iCLK);
    #1;
    $display("Result: errors=%0d of %0d checks",
             nErr, nChk);
    $finish;
  end

endmodule
